score_timer_ctrl: RTL and testbench

Run-control sequencer for the survival-time display. Generates timed single-cycle count strobes into the decimal digit chain (least-significant digit's count input) and a clear strobe to its reset input, and runs the start/pause/stop/restart state machine for one game. Tracks elapsed ticks in binary and holds the best run's tick count. Sits between the game logic (start/death/pause events) and the digit-counter chain.

---
 rtl/score_timer_ctrl_if.sv | 30 +++
 rtl/score_timer_ctrl.sv | 129 ++++++++++++
 tb/tb_score_timer_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/score_timer_ctrl_if.sv
// Game-side <-> run-control bundle for the survival-time display sequencer.
// The game logic owns the event inputs; the controller owns the strobes and status.
interface score_timer_ctrl_if #(
    parameter int TICK_W = 16
);
    logic              start;
    logic              stop;
    logic              pause;
    logic              chain_overflow;
    logic              digit_count;
    logic              digit_reset;
    logic              running;
    logic              paused;
    logic              maxed;
    logic [TICK_W-1:0] elapsed;
    logic [TICK_W-1:0] best;
    logic              new_best;

    modport master (
        output start, stop, pause, chain_overflow,
        input  digit_count, digit_reset, running, paused, maxed,
        input  elapsed, best, new_best
    );

    modport slave (
        input  start, stop, pause, chain_overflow,
        output digit_count, digit_reset, running, paused, maxed,
        output elapsed, best, new_best
    );
endinterface

// File: rtl/score_timer_ctrl.sv
// Run-control sequencer: paces count strobes into the decimal digit chain and
// runs the start/pause/stop/restart state machine, tracking elapsed and best ticks.
module score_timer_ctrl #(
    parameter int CLKS_PER_TICK = 5000000,
    parameter int TICK_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    score_timer_ctrl_if.slave   bus
);
    localparam int PRE_W = $clog2(CLKS_PER_TICK);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLKS_PER_TICK - 1);
    localparam logic [TICK_W-1:0] ELAPSED_MAX = {TICK_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_PAUSE,
        S_DONE,
        S_MAXED
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [TICK_W-1:0] elapsed_q, elapsed_d;
    logic [TICK_W-1:0] best_q, best_d;
    logic              digit_count_q, digit_count_d;
    logic              digit_reset_q, digit_reset_d;
    logic              new_best_q, new_best_d;
    logic              running_q, paused_q, maxed_q;
    logic              tick;
    logic              run_active;

    assign tick       = (presc_q == PRE_LAST);
    assign run_active = (state_q == S_RUN) || (state_q == S_PAUSE);

    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        elapsed_d     = elapsed_q;
        best_d        = best_q;
        digit_count_d = 1'b0;
        digit_reset_d = 1'b0;
        new_best_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                digit_reset_d = 1'b1;
                presc_d       = '0;
                state_d       = S_RUN;
            end
            S_RUN: begin
                if (bus.chain_overflow)  state_d = S_MAXED;
                else if (bus.stop)       state_d = S_DONE;
                else if (bus.start)      state_d = S_CLEAR;
                else if (bus.pause)      state_d = S_PAUSE;
                else if (tick) begin
                    presc_d       = '0;
                    digit_count_d = 1'b1;
                    if (elapsed_q != ELAPSED_MAX) elapsed_d = elapsed_q + TICK_W'(1);
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
            S_PAUSE: begin
                if (bus.chain_overflow)  state_d = S_MAXED;
                else if (bus.stop)       state_d = S_DONE;
                else if (bus.start)      state_d = S_CLEAR;
                else if (!bus.pause)     state_d = S_RUN;
            end
            S_DONE, S_MAXED: begin
                if (bus.start) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase

        // A new run starts from a clean slate the moment CLEAR is entered.
        if (state_d == S_CLEAR) begin
            elapsed_d = '0;
            presc_d   = '0;
        end

        // Best is only judged on the edge a run finishes; ties keep the old record.
        if (run_active && ((state_d == S_DONE) || (state_d == S_MAXED)) &&
            (elapsed_q > best_q)) begin
            best_d     = elapsed_q;
            new_best_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            elapsed_q     <= '0;
            best_q        <= '0;
            digit_count_q <= 1'b0;
            digit_reset_q <= 1'b0;
            new_best_q    <= 1'b0;
            running_q     <= 1'b0;
            paused_q      <= 1'b0;
            maxed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            elapsed_q     <= elapsed_d;
            best_q        <= best_d;
            digit_count_q <= digit_count_d;
            digit_reset_q <= digit_reset_d;
            new_best_q    <= new_best_d;
            running_q     <= (state_d == S_RUN);
            paused_q      <= (state_d == S_PAUSE);
            maxed_q       <= (state_d == S_MAXED);
        end
    end

    assign bus.digit_count = digit_count_q;
    assign bus.digit_reset = digit_reset_q;
    assign bus.running     = running_q;
    assign bus.paused      = paused_q;
    assign bus.maxed       = maxed_q;
    assign bus.elapsed     = elapsed_q;
    assign bus.best        = best_q;
    assign bus.new_best    = new_best_q;
endmodule

// File: tb/tb_score_timer_ctrl.sv
// Directed bench for score_timer_ctrl: one 16-bit instance for run control,
// one 3-bit instance for elapsed saturation; both at 4 clocks per tick.
module tb_score_timer_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;
    int   seen;

    score_timer_ctrl_if #(.TICK_W(16)) ifa ();
    score_timer_ctrl_if #(.TICK_W(3))  ifb ();

    score_timer_ctrl #(.CLKS_PER_TICK(4), .TICK_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    score_timer_ctrl #(.CLKS_PER_TICK(4), .TICK_W(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
        $display("check %-22s got=%0d exp=%0d", tag, obs, exp);
    endtask

    function automatic logic strobe(input int which);
        return (which == 0) ? ifa.digit_count : ifb.digit_count;
    endfunction

    // Steps until n strobes are seen (bounded); returns cycles taken.
    task automatic count_strobes(input int which, input int n, output int cycles);
        int got;
        got    = 0;
        cycles = 0;
        while (got < n && cycles < 400) begin
            step();
            cycles++;
            if (strobe(which)) got++;
        end
        check("strobe_budget", got, n);
    endtask

    // Pulse start for one cycle, then step into RUN (digit_reset visible).
    task automatic start_run(input int which);
        if (which == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
        step();
        if (which == 0) ifa.start = 1'b0; else ifb.start = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        ifa.start = 0; ifa.stop = 0; ifa.pause = 0; ifa.chain_overflow = 0;
        ifb.start = 0; ifb.stop = 0; ifb.pause = 0; ifb.chain_overflow = 0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_running",  ifa.running, 0);
        check("rst_paused",   ifa.paused, 0);
        check("rst_maxed",    ifa.maxed, 0);
        check("rst_dcount",   ifa.digit_count, 0);
        check("rst_dreset",   ifa.digit_reset, 0);
        check("rst_new_best", ifa.new_best, 0);
        check("rst_elapsed",  ifa.elapsed, 0);
        check("rst_best",     ifa.best, 0);

        // Overflow/stop in IDLE are ignored
        ifa.chain_overflow = 1; ifa.stop = 1;
        step();
        ifa.chain_overflow = 0; ifa.stop = 0;
        check("idle_ovf_maxed", ifa.maxed, 0);
        step();

        // Start: CLEAR cycle, then digit_reset pulse together with running
        ifa.start = 1;
        step();
        ifa.start = 0;
        check("clear_running", ifa.running, 0);
        step();
        check("clr_dreset", ifa.digit_reset, 1);
        check("clr_running", ifa.running, 1);
        check("clr_elapsed", ifa.elapsed, 0);
        step();
        check("clr_dreset_off", ifa.digit_reset, 0);
        count_strobes(0, 1, cyc);
        check("first_strobe_cyc", cyc, 3);
        check("elapsed_1", ifa.elapsed, 1);
        count_strobes(0, 9, cyc);
        check("nine_strobes_cyc", cyc, 36);
        check("elapsed_10", ifa.elapsed, 10);

        // Restart mid-run, then pause with prescaler held at 2
        ifa.start = 1;
        step();
        ifa.start = 0;
        check("rs10_elapsed0", ifa.elapsed, 0);
        step();
        check("rs10_dreset", ifa.digit_reset, 1);
        count_strobes(0, 6, cyc);
        check("six_strobes_cyc", cyc, 24);
        check("elapsed_6", ifa.elapsed, 6);
        step();
        step();
        ifa.pause = 1;
        step();
        check("pause_paused", ifa.paused, 1);
        check("pause_running", ifa.running, 0);
        seen = 0;
        for (int i = 0; i < 19; i++) begin
            step();
            if (ifa.digit_count) seen++;
        end
        check("pause_no_strobes", seen, 0);
        check("pause_elapsed", ifa.elapsed, 6);
        ifa.pause = 0;
        step();
        check("resume_running", ifa.running, 1);
        count_strobes(0, 1, cyc);
        check("resume_strobe_cyc", cyc, 2);
        check("elapsed_7", ifa.elapsed, 7);

        // Restart at elapsed 7, run 5 ticks, stop -> first best
        ifa.start = 1;
        step();
        ifa.start = 0;
        check("rs7_elapsed0", ifa.elapsed, 0);
        step();
        check("rs7_dreset", ifa.digit_reset, 1);
        check("rs7_best", ifa.best, 0);
        count_strobes(0, 5, cyc);
        check("five_strobes_cyc", cyc, 20);
        ifa.stop = 1;
        step();
        ifa.stop = 0;
        check("done_best", ifa.best, 5);
        check("done_new_best", ifa.new_best, 1);
        check("done_running", ifa.running, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ifa.digit_count) seen++;
        end
        check("done_nb_off", ifa.new_best, 0);
        check("done_no_strobes", seen, 0);

        // Shorter run and equal run leave best alone
        start_run(0);
        count_strobes(0, 3, cyc);
        ifa.stop = 1;
        step();
        ifa.stop = 0;
        check("run3_elapsed", ifa.elapsed, 3);
        check("run3_best", ifa.best, 5);
        check("run3_new_best", ifa.new_best, 0);
        start_run(0);
        count_strobes(0, 5, cyc);
        ifa.stop = 1;
        step();
        ifa.stop = 0;
        check("run5eq_best", ifa.best, 5);
        check("run5eq_new_best", ifa.new_best, 0);

        // Stop on the cycle the prescaler is at its last count
        start_run(0);
        count_strobes(0, 2, cyc);
        step();
        step();
        step();
        ifa.stop = 1;
        step();
        ifa.stop = 0;
        check("stoptick_dcount", ifa.digit_count, 0);
        check("stoptick_elapsed", ifa.elapsed, 2);
        check("stoptick_running", ifa.running, 0);

        // Overflow wins over stop in the same cycle
        start_run(0);
        count_strobes(0, 6, cyc);
        ifa.chain_overflow = 1;
        ifa.stop = 1;
        step();
        ifa.chain_overflow = 0;
        ifa.stop = 0;
        check("ovf_maxed", ifa.maxed, 1);
        check("ovf_best", ifa.best, 6);
        check("ovf_new_best", ifa.new_best, 1);
        check("ovf_running", ifa.running, 0);
        step();
        check("ovf_maxed_hold", ifa.maxed, 1);
        check("ovf_nb_off", ifa.new_best, 0);

        // Reset mid-run just before a tick
        start_run(0);
        count_strobes(0, 1, cyc);
        step();
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        check("mrst_dcount", ifa.digit_count, 0);
        check("mrst_running", ifa.running, 0);
        check("mrst_elapsed", ifa.elapsed, 0);
        check("mrst_best", ifa.best, 0);
        step();
        check("mrst_dcount2", ifa.digit_count, 0);

        // 3-bit counter saturates at 7 while strobes continue
        start_run(1);
        check("sat_dreset", ifb.digit_reset, 1);
        count_strobes(1, 9, cyc);
        check("sat_strobes_cyc", cyc, 36);
        check("sat_elapsed", ifb.elapsed, 7);
        step();
        reset = 1;
        step();
        reset = 0;
        check("sat_rst_running", ifb.running, 0);
        check("sat_rst_elapsed", ifb.elapsed, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
